lsu_resp_unit: RTL and testbench
================================

// Module: lsu_resp_unit
// PURPOSE
// Memory-side partner of the address-generation stage. Takes the AGU's accepted access
// (ce, v_addr, mem_ctrl, store data) and issues it to the data cache over an
// addr_ok/data_ok split handshake. It tracks up to DEPTH outstanding accesses, then
// aligns, merges and sign-extends returned load data into a registered writeback.
// It sits between the AGU/EX stage and the writeback (WB) stage.
// PARAMETERS
// DEPTH   2   max outstanding cache requests (power of 2, >=2)
// ADDR_W  32  address width
// DATA_W  32  data width (byte lanes = DATA_W/8)
// PORTS
// clk         in   1       core clock
// resetn      in   1       asynchronous active-low reset
// flush       in   1       pipeline flush (exception/eret)
// req_valid   in   1       AGU access valid (ce, exception-free)
// req_addr    in   ADDR_W  virtual address from AGU
// req_wr      in   1       1=store, 0=load
// req_size    in   2       0=byte, 1=half, 2=word
// req_uns     in   1       unsigned load (LBU/LHU)
// req_ul      in   1       unaligned-left (LWL/SWL)
// req_ur      in   1       unaligned-right (LWR/SWR)
// req_wdata   in   DATA_W  store data (rt)
// req_old     in   DATA_W  current rt value, merge source for LWL/LWR
// req_waddr   in   5       destination GPR
// req_ready   out  1       access accepted this cycle
// d_req       out  1       cache request valid
// d_wr        out  1       cache write
// d_size      out  2       cache size
// d_addr      out  ADDR_W  cache address
// d_wstrb     out  4       byte-lane strobes
// d_wdata     out  DATA_W  lane-aligned store data
// d_addr_ok   in   1       cache accepted the request
// d_data_ok   in   1       in-order response (read data or write done)
// d_rdata     in   DATA_W  read data
// wb_valid    out  1       load result valid
// wb_addr     out  5       destination GPR
// wb_data     out  DATA_W  aligned load result
// busy        out  1       queue non-empty (stall source for later accesses)
// BEHAVIOUR
// - Reset: queue empty; wb_valid=0, wb_addr=0, wb_data=0; busy=0; all kill bits 0.
// - d_req = req_valid & !full & !flush. Requests are issued combinationally from the inputs.
// - req_ready = d_req & d_addr_ok. Only on req_ready is an entry pushed to the FIFO.
// - Entry fields: wr, size, uns, ul, ur, addr[1:0], old, waddr, kill=0.
// - Pop the head on d_data_ok. d_data_ok while the queue is empty is a protocol error
//   and is ignored (assertion fires). Push and pop may occur in the same cycle; when full,
//   a same-cycle pop does NOT enable a push (full stays registered).
// - Pointers are log2(DEPTH)+1 bits with wrap; full and empty use the MSB compare.
// - Flush: set kill on every valid entry; no push occurs that cycle. Killed responses are
//   popped without writeback. A flush on the same cycle as a pop pops and kills the rest.
// - Unaligned access (ul|ur): d_addr={addr[31:2],2'b00}, d_size=2. Other accesses pass
//   addr and size through unchanged.
// - Strobes, with off=addr[1:0]:
//   - byte: 1<<off
//   - half: 3<<off
//   - word: 4'hF
//   - SWL: 0001/0011/0111/1111 for off 0..3; wdata >> 8*(3-off)
//   - SWR: 1111/1110/1100/1000; wdata << 8*off
//   - byte/half: wdata replicated across lanes
// - Load extraction, little-endian:
//   - byte: rdata[8*off+:8]
//   - half: rdata[8*off+:16], with off[0]=0
//   - both are sign-extended unless uns
//   - LWL off0..3: {rd[7:0],old[23:0]}, {rd[15:0],old[15:0]}, {rd[23:0],old[7:0]}, rd
//   - LWR off0..3: rd, {old[31:24],rd[31:8]}, {old[31:16],rd[31:16]}, {old[31:8],rd[31:24]}
// - Writeback is registered: wb_valid=1 exactly one cycle after d_data_ok for an unkilled
//   load, otherwise 0. flush clears wb_valid in the next cycle.
// - Stores produce no writeback. busy = !empty.
// - Async reset mid-transaction drops all entries. The cache is reset on the same
//   resetn, so no stale responses arrive.
// STRUCTURE
// - Shared package cpu_pkg: mem_req_t (entry struct), size encodings SZ_B/SZ_H/SZ_W,
//   function load_align(rdata, old, off, size, uns, ul, ur).
// - One sub-module lsu_req_fifo: parameterized DEPTH queue with push/pop/full/empty
//   and a bulk kill input.
// - Top level: strobe/data steering (comb), FIFO instance, writeback register.
// TESTING
// - LB addr=0x...3, rdata=0x80FF_0000, uns=0 -> wb_data=0xFFFF_FF80, wb_valid one cycle
//   after d_data_ok.
// - SWL addr off=1, wdata=0xAABBCCDD -> d_addr aligned, d_wstrb=0011, d_wdata[15:0]=0xAABB.
// - LWR off=2, old=0x11223344, rdata=0x55667788 -> wb_data=0x11225566.
// - Issue 2 loads with addr_ok, hold data_ok -> 3rd req_valid sees req_ready=0, busy=1;
//   one data_ok then re-accept.
// - 2 outstanding loads, flush, then 2 data_ok -> no wb_valid, queue empty; next load
//   writes back normally.
// - Random addr_ok/data_ok stalls against a scoreboard -> in-order writeback matches the
//   reference load_align.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared LSU types: queued access descriptor, size encodings and the
// load-result alignment function used at writeback.
package cpu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic        ul;
        logic        ur;
        logic [1:0]  off;
        logic [31:0] old;
        logic [4:0]  waddr;
        logic        kill;
    } mem_req_t;

    // Little-endian lane extraction; LWL/LWR merge returned bytes into old rt.
    function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                               input logic [31:0] old,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns,
                                               input logic        ul,
                                               input logic        ur);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        b   = rdata[{off, 3'b000} +: 8];
        h   = rdata[{off[1], 4'b0000} +: 16];
        res = rdata;
        if (ul) begin
            case (off)
                2'd0:    res = {rdata[7:0],  old[23:0]};
                2'd1:    res = {rdata[15:0], old[15:0]};
                2'd2:    res = {rdata[23:0], old[7:0]};
                default: res = rdata;
            endcase
        end else if (ur) begin
            case (off)
                2'd0:    res = rdata;
                2'd1:    res = {old[31:24], rdata[31:8]};
                2'd2:    res = {old[31:16], rdata[31:16]};
                default: res = {old[31:8],  rdata[31:24]};
            endcase
        end else if (size == SZ_B) begin
            res = {{24{b[7] & ~uns}}, b};
        end else if (size == SZ_H) begin
            res = {{16{h[15] & ~uns}}, h};
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_req_fifo.sv
// In-order queue of outstanding cache accesses with a bulk kill that marks
// every live entry so its response is dropped instead of written back.
module lsu_req_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     push,
    input  mem_req_t push_data,
    input  logic     pop,
    input  logic     kill,
    output mem_req_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    mem_req_t         mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [AW:0]      count;
    logic [AW-1:0]    rel;
    logic [DEPTH-1:0] in_use;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;
    assign head  = mem_q[rptr_q[AW-1:0]];

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        in_use = '0;
        rel    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel       = AW'(i) - rptr_q[AW-1:0];
            in_use[i] = ({1'b0, rel} < count);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push && !full) begin
                mem_q[wptr_q[AW-1:0]] <= push_data;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (pop && !empty) rptr_q <= rptr_q + 1'b1;
            if (kill) begin
                for (int i = 0; i < DEPTH; i++)
                    if (in_use[i]) mem_q[i].kill <= 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!resetn) !(pop && empty));

endmodule

// File: rtl/lsu_resp_unit.sv
// Issues AGU accesses to the data cache, tracks them in order and returns
// aligned/sign-extended load data through a registered writeback port.
module lsu_resp_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_uns,
    input  logic              req_ul,
    input  logic              req_ur,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_old,
    input  logic [4:0]        req_waddr,
    output logic              req_ready,
    output logic              d_req,
    output logic              d_wr,
    output logic [1:0]        d_size,
    output logic [ADDR_W-1:0] d_addr,
    output logic [3:0]        d_wstrb,
    output logic [DATA_W-1:0] d_wdata,
    input  logic              d_addr_ok,
    input  logic              d_data_ok,
    input  logic [DATA_W-1:0] d_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              busy
);
    mem_req_t          push_entry;
    mem_req_t          head;
    logic              full;
    logic              empty;
    logic              unaligned;
    logic [1:0]        off;
    logic              wb_valid_d, wb_valid_q;
    logic [4:0]        wb_addr_d, wb_addr_q;
    logic [DATA_W-1:0] wb_data_d, wb_data_q;

    // Handshake: a cache request is presented while req_valid, not full and not
    // flushing; it is accepted (and queued) only in a cycle where d_addr_ok is also high.
    assign d_req     = req_valid & ~full & ~flush;
    assign req_ready = d_req & d_addr_ok;

    assign off       = req_addr[1:0];
    assign unaligned = req_ul | req_ur;
    assign d_wr      = req_wr;
    assign d_addr    = unaligned ? {req_addr[ADDR_W-1:2], 2'b00} : req_addr;
    assign d_size    = unaligned ? SZ_W : req_size;

    always_comb begin
        d_wstrb = 4'hF;
        d_wdata = req_wdata;
        if (req_ul) begin
            d_wdata = req_wdata >> {2'd3 - off, 3'b000};
            case (off)
                2'd0:    d_wstrb = 4'b0001;
                2'd1:    d_wstrb = 4'b0011;
                2'd2:    d_wstrb = 4'b0111;
                default: d_wstrb = 4'b1111;
            endcase
        end else if (req_ur) begin
            d_wdata = req_wdata << {off, 3'b000};
            d_wstrb = 4'b1111 << off;
        end else if (req_size == SZ_B) begin
            d_wdata = {4{req_wdata[7:0]}};
            d_wstrb = 4'b0001 << off;
        end else if (req_size == SZ_H) begin
            d_wdata = {2{req_wdata[15:0]}};
            d_wstrb = 4'b0011 << off;
        end
    end

    assign push_entry = '{wr: req_wr, size: req_size, uns: req_uns, ul: req_ul,
                          ur: req_ur, off: off, old: req_old, waddr: req_waddr,
                          kill: 1'b0};

    lsu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (req_ready),
        .push_data (push_entry),
        .pop       (d_data_ok),
        .kill      (flush),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // A response popped in a flush cycle belongs to a squashed access as well.
    assign wb_valid_d = d_data_ok & ~empty & ~head.kill & ~head.wr & ~flush;
    assign wb_addr_d  = wb_valid_d ? head.waddr : wb_addr_q;
    assign wb_data_d  = wb_valid_d ? load_align(d_rdata, head.old, head.off, head.size,
                                                head.uns, head.ul, head.ur)
                                   : wb_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign busy     = ~empty;

endmodule

// File: tb/tb_lsu_resp_unit.sv
// Bench for lsu_resp_unit: directed vectors with literal expectations plus a
// queue-based behavioural model compared against the DUT every cycle.
module tb_lsu_resp_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        flush, req_valid, req_wr, req_uns, req_ul, req_ur;
    logic [31:0] req_addr, req_wdata, req_old, d_rdata;
    logic [1:0]  req_size;
    logic [4:0]  req_waddr;
    logic        req_ready, d_req, d_wr, d_addr_ok, d_data_ok, wb_valid, busy;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, wb_data;
    logic [3:0]  d_wstrb;
    logic [4:0]  wb_addr;

    int n_checks = 0;
    int n_pass   = 0;
    logic started = 1'b0;

    lsu_resp_unit #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .req_valid(req_valid),
        .req_addr(req_addr), .req_wr(req_wr), .req_size(req_size), .req_uns(req_uns),
        .req_ul(req_ul), .req_ur(req_ur), .req_wdata(req_wdata), .req_old(req_old),
        .req_waddr(req_waddr), .req_ready(req_ready), .d_req(d_req), .d_wr(d_wr),
        .d_size(d_size), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- reference rules ----------------
    function automatic logic [31:0] ref_align(input logic [31:0] rd, input logic [31:0] old,
                                              input logic [1:0] off, input logic [1:0] sz,
                                              input logic uns, input logic ul, input logic ur);
        int o;
        logic [31:0] v;
        o = int'(off);
        if (ul) return (rd << (8 * (3 - o))) | (old & ((32'h1 << (8 * (3 - o))) - 32'h1));
        if (ur) return (rd >> (8 * o)) | (old & ~(32'hFFFF_FFFF >> (8 * o)));
        v = rd >> (8 * o);
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic void ref_steer(input logic [31:0] a, input logic [31:0] w,
                                      input logic [1:0] sz, input logic ul, input logic ur,
                                      output logic [31:0] da, output logic [1:0] ds,
                                      output logic [3:0] st, output logic [31:0] dw);
        int o;
        o = int'(a[1:0]);
        da = (ul || ur) ? (a & 32'hFFFF_FFFC) : a;
        ds = (ul || ur) ? 2'd2 : sz;
        if (ul) begin
            st = 4'((32'h1 << (o + 1)) - 1);
            dw = w >> (8 * (3 - o));
        end else if (ur) begin
            st = 4'(32'hF << o);
            dw = w << (8 * o);
        end else if (sz == 2'd0) begin
            st = 4'(32'h1 << o);
            dw = w[7:0] * 32'h0101_0101;
        end else if (sz == 2'd1) begin
            st = 4'(32'h3 << o);
            dw = w[15:0] * 32'h0001_0001;
        end else begin
            st = 4'hF;
            dw = w;
        end
    endfunction

    // ---------------- behavioural model / scoreboard ----------------
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        uns, ul, ur;
        logic [1:0]  off;
        logic [31:0] old;
        logic [4:0]  waddr;
        logic        kill;
    } m_ent_t;

    m_ent_t      pend[$];
    m_ent_t      e;
    logic [36:0] exp_q[$];
    logic        m_wb_valid = 1'b0;
    logic        acc;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend.delete();
            exp_q.delete();
            m_wb_valid = 1'b0;
        end else begin
            acc = req_valid && !flush && (pend.size() < DEPTH) && d_addr_ok;
            m_wb_valid = 1'b0;
            if (d_data_ok && pend.size() > 0) begin
                e = pend.pop_front();
                if (!e.wr && !e.kill && !flush) begin
                    m_wb_valid = 1'b1;
                    exp_q.push_back({e.waddr, ref_align(d_rdata, e.old, e.off, e.size,
                                                        e.uns, e.ul, e.ur)});
                end
            end
            if (flush) foreach (pend[i]) pend[i].kill = 1'b1;
            if (acc) pend.push_back('{req_wr, req_size, req_uns, req_ul, req_ur,
                                      req_addr[1:0], req_old, req_waddr, 1'b0});
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] x_addr, x_wdata, x_item;
    logic [1:0]  x_size;
    logic [3:0]  x_strb;
    logic        x_dreq;

    always @(negedge clk) begin
        if (resetn && started) begin
            x_dreq = req_valid && !flush && (pend.size() < DEPTH);
            check("d_req", d_req, x_dreq);
            check("req_ready", req_ready, x_dreq && d_addr_ok);
            check("busy", busy, pend.size() != 0);
            if (x_dreq) begin
                ref_steer(req_addr, req_wdata, req_size, req_ul, req_ur,
                          x_addr, x_size, x_strb, x_wdata);
                check("d_addr", d_addr, x_addr);
                check("d_size", d_size, x_size);
                check("d_wr", d_wr, req_wr);
                check("d_wstrb", d_wstrb, x_strb);
                check("d_wdata", d_wdata, x_wdata);
            end
            check("wb_valid", wb_valid, m_wb_valid);
            if (m_wb_valid && exp_q.size() > 0) begin
                x_item = exp_q[0][31:0];
                check("wb_addr", wb_addr, exp_q[0][36:32]);
                check("wb_data", wb_data, x_item);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; req_valid = 0; req_wr = 0; req_size = 0; req_uns = 0;
        req_ul = 0; req_ur = 0; req_addr = 0; req_wdata = 0; req_old = 0;
        req_waddr = 0; d_addr_ok = 0; d_data_ok = 0; d_rdata = 0;
    endtask

    task automatic set_req(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                           input logic uns, input logic ul, input logic ur,
                           input logic [31:0] wdata, input logic [31:0] old,
                           input logic [4:0] waddr);
        req_valid = 1; req_wr = wr; req_addr = addr; req_size = sz; req_uns = uns;
        req_ul = ul; req_ur = ur; req_wdata = wdata; req_old = old; req_waddr = waddr;
    endtask

    // ---------------- stimulus ----------------
    int          kind;
    logic [31:0] ra;

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_busy", busy, 0);
        resetn = 1;
        started = 1;
        tick();

        // LB at offset 3, signed
        set_req(0, 32'h0000_1003, 2'd0, 0, 0, 0, 0, 0, 5'd5);
        d_addr_ok = 1;
        tick();
        idle();
        d_data_ok = 1; d_rdata = 32'h80FF_0000;
        #1 check("lb_wb_not_yet", wb_valid, 0);
        tick();
        check("lb_wb_valid", wb_valid, 1);
        check("lb_wb_data", wb_data, 32'hFFFF_FF80);
        check("lb_wb_addr", wb_addr, 5);
        d_data_ok = 0;
        tick();
        check("lb_wb_one_cycle", wb_valid, 0);

        // SWL at offset 1
        set_req(1, 32'h0000_2001, 2'd2, 0, 1, 0, 32'hAABB_CCDD, 0, 0);
        #1;
        check("swl_addr", d_addr, 32'h0000_2000);
        check("swl_size", d_size, 2);
        check("swl_strb", d_wstrb, 4'b0011);
        check("swl_wdata_lo", d_wdata[15:0], 16'hAABB);
        check("swl_no_ready", req_ready, 0);
        d_addr_ok = 1;
        #1 check("swl_ready", req_ready, 1);
        tick();
        idle();
        d_data_ok = 1;
        tick();
        d_data_ok = 0;
        tick();
        check("swl_no_wb", wb_valid, 0);
        check("swl_idle", busy, 0);

        // LWR at offset 2
        set_req(0, 32'h0000_3002, 2'd2, 0, 0, 1, 0, 32'h1122_3344, 5'd7);
        d_addr_ok = 1;
        tick();
        idle();
        d_data_ok = 1; d_rdata = 32'h5566_7788;
        tick();
        d_data_ok = 0;
        check("lwr_wb_valid", wb_valid, 1);
        check("lwr_wb_data", wb_data, 32'h1122_5566);

        // Fill the queue, then back-pressure
        set_req(0, 32'h0000_4000, 2'd2, 0, 0, 0, 0, 0, 5'd1);
        d_addr_ok = 1;
        tick();
        set_req(0, 32'h0000_4004, 2'd2, 0, 0, 0, 0, 0, 5'd2);
        tick();
        set_req(0, 32'h0000_4008, 2'd2, 0, 0, 0, 0, 0, 5'd3);
        #1;
        check("full_no_ready", req_ready, 0);
        check("full_busy", busy, 1);
        tick();
        d_data_ok = 1; d_rdata = 32'h1234_5678;
        #1 check("full_pop_no_push", req_ready, 0);
        tick();
        d_data_ok = 0;
        check("full_wb_data", wb_data, 32'h1234_5678);
        check("full_reaccept", req_ready, 1);
        tick();
        idle();
        d_data_ok = 1; d_rdata = 32'h0000_0022;
        tick();
        d_rdata = 32'h0000_0033;
        tick();
        d_data_ok = 0;
        check("drain_wb_addr", wb_addr, 3);
        tick();
        check("drain_empty", busy, 0);

        // Flush kills outstanding loads
        set_req(0, 32'h0000_5000, 2'd2, 0, 0, 0, 0, 0, 5'd10);
        d_addr_ok = 1;
        tick();
        set_req(0, 32'h0000_5004, 2'd2, 0, 0, 0, 0, 0, 5'd11);
        tick();
        idle();
        flush = 1;
        tick();
        flush = 0; d_data_ok = 1; d_rdata = 32'hDEAD_BEEF;
        tick();
        check("flush_no_wb0", wb_valid, 0);
        tick();
        d_data_ok = 0;
        check("flush_no_wb1", wb_valid, 0);
        check("flush_empty", busy, 0);
        set_req(0, 32'h0000_6000, 2'd2, 0, 0, 0, 0, 0, 5'd9);
        d_addr_ok = 1;
        tick();
        idle();
        d_data_ok = 1; d_rdata = 32'hCAFE_F00D;
        tick();
        d_data_ok = 0;
        check("post_flush_wb_valid", wb_valid, 1);
        check("post_flush_wb_data", wb_data, 32'hCAFE_F00D);

        // Random stalls, flushes and access types against the model
        for (int c = 0; c < 600; c++) begin
            kind = $urandom_range(0, 4);
            ra = $urandom;
            if (kind == 1) ra[0] = 1'b0;
            if (kind == 2) ra[1:0] = 2'b00;
            set_req($urandom_range(0, 1), ra, (kind <= 2) ? 2'(kind) : 2'd2,
                    $urandom_range(0, 1), kind == 3, kind == 4,
                    $urandom, $urandom, 5'($urandom_range(0, 31)));
            req_valid = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            d_addr_ok = $urandom_range(0, 1);
            d_data_ok = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
            d_rdata   = $urandom;
            tick();
        end
        idle();
        while (pend.size() > 0) begin
            d_data_ok = 1;
            tick();
        end
        d_data_ok = 0;
        tick();

        // Asynchronous reset with an access in flight
        set_req(0, 32'h0000_7000, 2'd2, 0, 0, 0, 0, 0, 5'd4);
        d_addr_ok = 1;
        tick();
        idle();
        #1 resetn = 0;
        #2;
        check("areset_busy", busy, 0);
        check("areset_wb_valid", wb_valid, 0);
        @(posedge clk);
        #1 resetn = 1;
        set_req(0, 32'h0000_7001, 2'd0, 1, 0, 0, 0, 0, 5'd6);
        d_addr_ok = 1;
        tick();
        idle();
        d_data_ok = 1; d_rdata = 32'h0000_9A00;
        tick();
        d_data_ok = 0;
        check("after_reset_wb_data", wb_data, 32'h0000_009A);
        check("after_reset_wb_addr", wb_addr, 6);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
